// File: rtl/game_ctrl_if.sv
// Snake game controller bus: mode enum package plus the interface carrying
// game events in and screen/score state out.
package snake_pkg;
    typedef enum logic [1:0] {
        MODE_MENU = 2'd0,
        MODE_GAME = 2'd1,
        MODE_END  = 2'd2
    } mode_t;
endpackage

interface game_ctrl_if #(
    parameter int unsigned SCORE_W = 8
);
    logic                 tick;
    logic                 left;
    logic                 right;
    logic                 collision;
    logic                 food;
    snake_pkg::mode_t     mode;
    logic                 move_en;
    logic                 map_clr;
    logic [1:0]           count;
    logic [SCORE_W-1:0]   score;
    logic [SCORE_W-1:0]   best;

    modport master (
        output tick, left, right, collision, food,
        input  mode, move_en, map_clr, count, score, best
    );

    modport slave (
        input  tick, left, right, collision, food,
        output mode, move_en, map_clr, count, score, best
    );
endinterface

// File: rtl/game_ctrl.sv
// Snake game sequencer: menu, countdown, run, pause and game-over handling,
// with score/best tracking and edge-detected mouse buttons.
module game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned COUNT_TICKS = 3,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    game_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RUN       = 3'd2,
        S_PAUSE     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [1:0]         COUNT_INIT = 2'(COUNT_TICKS);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_left_q;
    logic                 r_right_q;
    mode_t                r_mode;
    logic                 r_move_en;
    logic                 r_map_clr;
    logic [1:0]           r_count;
    logic [SCORE_W-1:0]   r_score;
    logic [SCORE_W-1:0]   r_best;

    mode_t                w_mode;
    logic                 w_move_en;
    logic                 w_map_clr;
    logic [1:0]           w_count;
    logic [SCORE_W-1:0]   w_score;
    logic [SCORE_W-1:0]   w_best;
    logic                 w_press_l;
    logic                 w_press_r;

    // Button history resets high so a button held through reset is not a press
    assign w_press_l = bus.left  & ~r_left_q;
    assign w_press_r = bus.right & ~r_right_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_MENU;
            r_left_q  <= 1'b1;
            r_right_q <= 1'b1;
            r_mode    <= MODE_MENU;
            r_move_en <= 1'b0;
            r_map_clr <= 1'b0;
            r_count   <= 2'd0;
            r_score   <= '0;
            r_best    <= '0;
        end else begin
            r_state   <= w_next_state;
            r_left_q  <= bus.left;
            r_right_q <= bus.right;
            r_mode    <= w_mode;
            r_move_en <= w_move_en;
            r_map_clr <= w_map_clr;
            r_count   <= w_count;
            r_score   <= w_score;
            r_best    <= w_best;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_MENU: begin
                if (w_press_l) w_next_state = S_COUNTDOWN;
            end
            S_COUNTDOWN: begin
                if (w_press_r)                         w_next_state = S_MENU;
                else if (bus.tick && r_count == 2'd1)  w_next_state = S_RUN;
            end
            S_RUN: begin
                if (bus.collision)  w_next_state = S_OVER;
                else if (w_press_r) w_next_state = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_press_l)      w_next_state = S_MENU;
                else if (w_press_r) w_next_state = S_RUN;
            end
            S_OVER: begin
                if (w_press_l)      w_next_state = S_COUNTDOWN;
                else if (w_press_r) w_next_state = S_MENU;
            end
            default: w_next_state = S_MENU;
        endcase
    end

    // Outputs are computed for the next state so they register on the transition edge
    always_comb begin
        w_map_clr = 1'b0;
        w_count   = r_count;
        w_score   = r_score;
        w_best    = r_best;
        w_mode    = MODE_MENU;
        w_move_en = 1'b0;
        case (r_state)
            S_MENU, S_OVER: begin
                if (w_next_state == S_COUNTDOWN) begin
                    w_map_clr = 1'b1;
                    w_count   = COUNT_INIT;
                    w_score   = '0;
                end
            end
            S_COUNTDOWN: begin
                if (w_press_r)     w_count = 2'd0;
                else if (bus.tick) w_count = r_count - 2'd1;
            end
            S_RUN: begin
                if (bus.collision) begin
                    if (r_score > r_best) w_best = r_score;
                end else if (bus.food && r_score != SCORE_MAX) begin
                    w_score = r_score + SCORE_W'(1);
                end
            end
            S_PAUSE: begin
                w_count = r_count;
            end
            default: begin
                w_count = 2'd0;
            end
        endcase

        w_move_en = (w_next_state == S_RUN);
        case (w_next_state)
            S_COUNTDOWN, S_RUN, S_PAUSE: w_mode = MODE_GAME;
            S_OVER:                      w_mode = MODE_END;
            default:                     w_mode = MODE_MENU;
        endcase
    end

    assign bus.mode    = r_mode;
    assign bus.move_en = r_move_en;
    assign bus.map_clr = r_map_clr;
    assign bus.count   = r_count;
    assign bus.score   = r_score;
    assign bus.best    = r_best;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed button/tick/food/collision vectors
// drive an 8-bit-score and a 2-bit-score instance in parallel.
module tb_game_ctrl;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0, left = 1'b1, right = 1'b0, collision = 1'b0, food = 1'b0;

    always #5 clk = ~clk;

    game_ctrl_if #(.SCORE_W(8)) b0 ();
    game_ctrl_if #(.SCORE_W(2)) b1 ();

    assign b0.tick = tick;  assign b0.left = left;  assign b0.right = right;
    assign b0.collision = collision;  assign b0.food = food;
    assign b1.tick = tick;  assign b1.left = left;  assign b1.right = right;
    assign b1.collision = collision;  assign b1.food = food;

    game_ctrl #(.COUNT_TICKS(3), .SCORE_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
    game_ctrl #(.COUNT_TICKS(3), .SCORE_W(2)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

    typedef struct packed {
        logic [1:0] mode;
        logic       move_en;
        logic       map_clr;
        logic [1:0] count;
        logic [7:0] score;
        logic [7:0] best;
    } obs_t;

    typedef struct {
        int    cyc;
        int    dut;
        string name;
        obs_t  exp;
    } ent_t;

    ent_t q[$];
    int   cyc_cnt = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;
    event chk_ev;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic obs_t sample(input int dut);
        obs_t o;
        if (dut == 0) begin
            o.mode = b0.mode;  o.move_en = b0.move_en;  o.map_clr = b0.map_clr;
            o.count = b0.count;  o.score = b0.score;  o.best = b0.best;
        end else begin
            o.mode = b1.mode;  o.move_en = b1.move_en;  o.map_clr = b1.map_clr;
            o.count = b1.count;  o.score = 8'(b1.score);  o.best = 8'(b1.best);
        end
        return o;
    endfunction

    // Monitor: pops every expectation due at this sample point and compares
    initial begin
        ent_t e;
        obs_t act;
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
                e   = q.pop_front();
                act = sample(e.dut);
                n_chk++;
                if (e.cyc != cyc_cnt || act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s dut%0d @cyc %0d: got mode=%0d move_en=%0d map_clr=%0d count=%0d score=%0d best=%0d, expected mode=%0d move_en=%0d map_clr=%0d count=%0d score=%0d best=%0d",
                             e.name, e.dut, cyc_cnt,
                             act.mode, act.move_en, act.map_clr, act.count, act.score, act.best,
                             e.exp.mode, e.exp.move_en, e.exp.map_clr, e.exp.count, e.exp.score, e.exp.best);
                end
            end
        end
    end

    task automatic push(input string nm, input int dut, input int due,
                        input logic [1:0] m, input logic me, input logic mc,
                        input logic [1:0] c, input logic [7:0] s, input logic [7:0] b);
        ent_t e;
        e.cyc = due;  e.dut = dut;  e.name = nm;
        e.exp.mode = m;  e.exp.move_en = me;  e.exp.map_clr = mc;
        e.exp.count = c;  e.exp.score = s;  e.exp.best = b;
        q.push_back(e);
    endtask

    // Expectation for both instances after the coming clock edge
    task automatic exb(input string nm, input logic [1:0] m, input logic me, input logic mc,
                       input logic [1:0] c, input logic [7:0] s0, input logic [7:0] bst0,
                       input logic [7:0] s1, input logic [7:0] bst1);
        push(nm, 0, cyc_cnt + 1, m, me, mc, c, s0, bst0);
        push(nm, 1, cyc_cnt + 1, m, me, mc, c, s1, bst1);
    endtask

    task automatic step(input logic t, input logic l, input logic r, input logic c, input logic f);
        @(negedge clk);
        tick = t;  left = l;  right = r;  collision = c;  food = f;
    endtask

    task automatic ticks3();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset held with left high; releasing reset must not count as a press
        step(0, 1, 0, 0, 0);  exb("reset_state", MODE_MENU, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);  rst = 1'b0;
        exb("held_left_release", MODE_MENU, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);  exb("held_left", MODE_MENU, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);  exb("start", MODE_GAME, 0, 1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);  exb("map_clr_single", MODE_GAME, 0, 0, 3, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);  exb("count2", MODE_GAME, 0, 0, 2, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);  exb("count1", MODE_GAME, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);  exb("run_entry", MODE_GAME, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 1);
            exb("food", MODE_GAME, 1, 0, 0, 8'(i), 0, 8'((i > 3) ? 3 : i), 0);
        end
        step(0, 0, 0, 1, 1);  exb("collide_over", MODE_END, 0, 0, 0, 5, 5, 3, 3);
        step(0, 0, 0, 1, 1);  exb("over_ignores", MODE_END, 0, 0, 0, 5, 5, 3, 3);

        // Both buttons in OVER: left wins and restarts
        step(0, 1, 1, 0, 0);  exb("over_restart", MODE_GAME, 0, 1, 3, 0, 5, 0, 3);
        step(0, 0, 0, 0, 0);  exb("restart_hold", MODE_GAME, 0, 0, 3, 0, 5, 0, 3);
        step(1, 0, 0, 0, 0);  exb("cd_tick", MODE_GAME, 0, 0, 2, 0, 5, 0, 3);
        step(1, 0, 1, 0, 0);  exb("cd_abort", MODE_MENU, 0, 0, 0, 0, 5, 0, 3);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);  exb("menu_right", MODE_MENU, 0, 0, 0, 0, 5, 0, 3);
        step(0, 0, 0, 0, 0);

        // Game ending at score 2 keeps best 5; pause behaviour
        step(0, 1, 0, 0, 0);  exb("start2", MODE_GAME, 0, 1, 3, 0, 5, 0, 3);
        step(0, 0, 0, 0, 0);
        ticks3();             exb("run2", MODE_GAME, 1, 0, 0, 0, 5, 0, 3);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);  exb("food2", MODE_GAME, 1, 0, 0, 2, 5, 2, 3);
        step(0, 1, 0, 0, 0);  exb("run_left_ignored", MODE_GAME, 1, 0, 0, 2, 5, 2, 3);
        step(1, 0, 1, 0, 0);  exb("pause", MODE_GAME, 0, 0, 0, 2, 5, 2, 3);
        step(0, 0, 0, 0, 1);  exb("pause_food", MODE_GAME, 0, 0, 0, 2, 5, 2, 3);
        step(0, 0, 0, 1, 0);  exb("pause_collision", MODE_GAME, 0, 0, 0, 2, 5, 2, 3);
        step(0, 0, 1, 0, 0);  exb("resume", MODE_GAME, 1, 0, 0, 2, 5, 2, 3);
        step(0, 0, 0, 1, 0);  exb("over_low_score", MODE_END, 0, 0, 0, 2, 5, 2, 3);
        step(0, 0, 1, 0, 0);  exb("over_to_menu", MODE_MENU, 0, 0, 0, 2, 5, 2, 3);
        step(0, 0, 0, 0, 0);

        // Both presses in PAUSE go to MENU
        step(0, 1, 0, 0, 0);  exb("start3", MODE_GAME, 0, 1, 3, 0, 5, 0, 3);
        step(0, 0, 0, 0, 0);
        ticks3();             exb("run3", MODE_GAME, 1, 0, 0, 0, 5, 0, 3);
        step(0, 0, 1, 0, 0);  exb("pause3", MODE_GAME, 0, 0, 0, 0, 5, 0, 3);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);  exb("pause_both", MODE_MENU, 0, 0, 0, 0, 5, 0, 3);
        step(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of RUN
        step(0, 1, 0, 0, 0);  exb("start4", MODE_GAME, 0, 1, 3, 0, 5, 0, 3);
        step(0, 0, 0, 0, 0);
        ticks3();
        step(0, 0, 0, 0, 1);  exb("run4_food", MODE_GAME, 1, 0, 0, 1, 5, 1, 3);
        @(negedge clk);
        food = 1'b0;
        #2 rst = 1'b1;
        #1;
        push("async_reset", 0, cyc_cnt, MODE_MENU, 0, 0, 0, 0, 0);
        push("async_reset", 1, cyc_cnt, MODE_MENU, 0, 0, 0, 0, 0);
        -> chk_ev;
        step(0, 0, 0, 0, 0);  exb("reset_hold", MODE_MENU, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);  rst = 1'b0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter COUNT_TICKS, default 3: tick pulses spent in COUNTDOWN; legal range 1..3.
REQ-002 Parameter SCORE_W, default 8: width of score and best.
REQ-003 clk  in  1  system clock; the single clock of the block.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 tick  in  1  one-cycle game-step pulse from the clock divider.
REQ-006 left  in  1  mouse left button level, already in the clk domain.
REQ-007 right  in  1  mouse right button level, already in the clk domain.
REQ-008 collision  in  1  one-cycle pulse from the move engine: the snake hit a wall or itself.
REQ-009 food  in  1  one-cycle pulse from the move engine: food was eaten.
REQ-010 mode  out  snake_pkg mode enum (MENU, GAME, END)  screen mode for the draw block.
REQ-011 move_en  out  1  move engine may advance on tick.
REQ-012 map_clr  out  1  one-cycle pulse that reinitialises the map and snake.
REQ-013 count  out  2  countdown digit to display; 0 outside COUNTDOWN.
REQ-014 score  out  SCORE_W  current game score.
REQ-015 best  out  SCORE_W  highest score since reset.

Function
REQ-016 Button press definitions:
- press_l = left & ~left_q, where left_q is left registered once.
- press_r is defined the same way from right.
- A button held across the reset release produces no press.
REQ-017 The FSM states are MENU, COUNTDOWN, RUN, PAUSE, OVER.
REQ-018 All outputs are registered and take their new-state values on the same edge as the state transition.
REQ-019 mode is MENU in MENU, GAME in COUNTDOWN/RUN/PAUSE, and END in OVER.
REQ-020 move_en is 1 exactly while the state is RUN.
REQ-021 MENU, press_l -> COUNTDOWN:
- map_clr = 1 for 1 cycle.
- score = 0.
- count = COUNT_TICKS.
REQ-022 MENU, press_r -> no effect.
REQ-023 COUNTDOWN, each tick: count decrements by 1.
REQ-024 COUNTDOWN, tick while count == 1 -> RUN, with count = 0.
REQ-025 COUNTDOWN, press_r -> MENU, with count = 0; press_r takes priority over tick.
REQ-026 RUN, food -> score + 1, saturating at 2^SCORE_W-1.
REQ-027 RUN, collision -> OVER; a same-cycle food is discarded, so score is unchanged.
REQ-028 RUN, press_r -> PAUSE; collision takes priority over press_r; press_l is ignored.
REQ-029 A tick that coincides with the RUN -> PAUSE transition is still qualified by move_en = 1; a tick on the next cycle is not.
REQ-030 PAUSE, press_r -> RUN.
REQ-031 PAUSE, press_l -> MENU; press_l takes priority when both presses occur in the same cycle.
REQ-032 PAUSE: collision and food are ignored.
REQ-033 OVER, entry: best = max(best, final score), updated on the entry edge.
REQ-034 OVER, press_l -> COUNTDOWN, with the same actions as REQ-021; press_l takes priority over press_r.
REQ-035 OVER, press_r -> MENU; score is held until the next game starts.
REQ-036 collision and food are ignored in every state other than RUN.
REQ-037 map_clr is never asserted for 2 consecutive cycles.
REQ-038 Unreachable state encodings recover to MENU on the next edge.

Reset
REQ-039 While rst = 1, and immediately when it asserts:
- state = MENU, mode = MENU.
- move_en = 0, map_clr = 0.
- count = 0, score = 0, best = 0.
- left_q = 1, right_q = 1.
REQ-040 rst asserted mid-game aborts the game with no map_clr pulse; best is cleared.

Verification
REQ-041 Reset with left held high, then release -> state stays MENU; a later release and re-press of left -> COUNTDOWN, map_clr pulse, count = 3.
REQ-042 Start a game, apply 3 ticks -> count goes 3, 2, 1, 0; RUN is entered on the 3rd tick and move_en = 1 on the following cycle.
REQ-043 In RUN, 5 food pulses then a collision coinciding with a 6th food -> score = 5, mode = END, best = 5, move_en = 0.
REQ-044 In RUN, press_r -> PAUSE with move_en = 0; food ignored; press_r -> RUN, score unchanged; press_l and press_r together in PAUSE -> MENU.
REQ-045 With SCORE_W = 2, 5 food pulses -> score = 3 (saturated).
REQ-046 OVER with best = 5, play a game ending at score = 2 -> best stays 5; assert rst in RUN -> all outputs return to their reset values asynchronously.
